// File: rtl/oc8051_cy_seq_if.sv
// Decoder-to-sequencer bundle: request side (start/mode/len/stall/alu_zero)
// and the carry-mux / PSW-write controls driven back by the sequencer.
interface oc8051_cy_seq_if #(
    parameter int IDX_W = 3
) ();
    // Handshake: start is a single-cycle request, accepted only while busy=0;
    // there is no ready/ack, a start seen while busy=1 is dropped, not queued.
    logic             start;
    logic [1:0]       mode;
    logic [3:0]       len;
    logic             stall;
    logic             alu_zero;
    logic [1:0]       cy_sel;
    logic             psw_cy_we;
    logic [IDX_W-1:0] byte_idx;
    logic             busy;
    logic             done;
    logic             all_zero;

    modport master (
        output start, mode, len, stall, alu_zero,
        input  cy_sel, psw_cy_we, byte_idx, busy, done, all_zero
    );

    modport slave (
        input  start, mode, len, stall, alu_zero,
        output cy_sel, psw_cy_we, byte_idx, busy, done, all_zero
    );
endinterface

// File: rtl/oc8051_cy_seq.sv
// Carry-chain sequencer: one byte per cycle, carry-in select and PSW.CY write strobe.
// Optional zero-flag accumulation is built when OC8051_CY_SEQ_ZFLAG_EN is defined.
module oc8051_cy_seq #(
    parameter int MAX_LEN = 8,
    parameter int IDX_W   = 3
) (
    input  logic               clk,
    input  logic               rst,
    oc8051_cy_seq_if.slave     bus,
    output logic [1:0]         state_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [1:0] MODE_ADD  = 2'b00;
    localparam logic [1:0] MODE_ADDC = 2'b01;
    localparam logic [1:0] MODE_SUB  = 2'b10;
    localparam logic [1:0] MODE_CYLD = 2'b11;

    localparam logic [1:0] CY_0   = 2'b00;
    localparam logic [1:0] CY_PSW = 2'b01;
    localparam logic [1:0] CY_RAM = 2'b10;
    localparam logic [1:0] CY_1   = 2'b11;

    localparam logic [4:0]       MAX_LEN_L  = 5'(MAX_LEN);
    localparam logic [IDX_W-1:0] MAX_LAST_L = IDX_W'(MAX_LEN - 1);

    state_e           state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] eff_last;
    logic [1:0]       first_sel;
    logic [1:0]       cy_sel_c;
    logic             psw_we_c;
    logic             busy_c;
    logic             done_c;
    logic             accept;
    logic             advance;

    // Index of the final byte; carry load is always a single byte.
    always_comb begin
        eff_last = '0;
        if (bus.mode == MODE_CYLD || bus.len == 4'd0) begin
            eff_last = '0;
        end else if ({1'b0, bus.len} > MAX_LEN_L) begin
            eff_last = MAX_LAST_L;
        end else begin
            eff_last = IDX_W'(bus.len - 4'd1);
        end
    end

    // Carry-in for byte 0; SUB seeds CY=1 for two's-complement borrow-in.
    always_comb begin
        first_sel = CY_PSW;
        case (mode_q)
            MODE_ADD:  first_sel = CY_0;
            MODE_ADDC: first_sel = CY_PSW;
            MODE_SUB:  first_sel = CY_1;
            MODE_CYLD: first_sel = CY_RAM;
            default:   first_sel = CY_PSW;
        endcase
    end

    assign accept  = (state_q == S_IDLE) && bus.start;
    assign advance = (state_q == S_RUN) && !bus.stall;

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        last_d   = last_q;
        idx_d    = idx_q;
        cy_sel_c = CY_PSW;
        psw_we_c = 1'b0;
        busy_c   = 1'b0;
        done_c   = 1'b0;
        case (state_q)
            S_IDLE: begin
                idx_d = '0;
                if (bus.start) begin
                    mode_d  = bus.mode;
                    last_d  = eff_last;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                busy_c   = 1'b1;
                cy_sel_c = (idx_q == '0) ? first_sel : CY_PSW;
                psw_we_c = !bus.stall;
                if (!bus.stall) begin
                    if (idx_q == last_q) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            S_DONE: begin
                busy_c  = 1'b1;
                done_c  = 1'b1;
                idx_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                idx_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            mode_q  <= MODE_ADD;
            last_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            last_q  <= last_d;
            idx_q   <= idx_d;
        end
    end

`ifdef OC8051_CY_SEQ_ZFLAG_EN
    logic zero_q, zero_d;

    // Accumulator holds after DONE so all_zero stays readable until the next start.
    always_comb begin
        zero_d = zero_q;
        if (accept) begin
            zero_d = 1'b1;
        end else if (advance) begin
            zero_d = zero_q & bus.alu_zero;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            zero_q <= 1'b0;
        end else begin
            zero_q <= zero_d;
        end
    end

    assign bus.all_zero = zero_q;
`else
    logic unused_alu_zero;
    assign unused_alu_zero = bus.alu_zero;
    assign bus.all_zero    = 1'b0;
`endif

    assign bus.cy_sel    = cy_sel_c;
    assign bus.psw_cy_we = psw_we_c;
    assign bus.byte_idx  = idx_q;
    assign bus.busy      = busy_c;
    assign bus.done      = done_c;
    assign state_o       = state_q;

`ifndef SYNTHESIS
    a_done_busy : assert property (@(posedge clk) disable iff (rst)
        bus.done |-> bus.busy);
    a_we_run : assert property (@(posedge clk) disable iff (rst)
        bus.psw_cy_we |-> (state_q == S_RUN));
    a_idx_range : assert property (@(posedge clk) disable iff (rst)
        (state_q == S_RUN) |-> (idx_q <= last_q));
    a_done_one : assert property (@(posedge clk) disable iff (rst)
        (state_q == S_DONE) |=> (state_q == S_IDLE));
`endif

endmodule

// File: tb/tb_oc8051_cy_seq.sv
// Directed bench for oc8051_cy_seq: vector table for full sequences plus
// hand-written stall, ignored-start and mid-run reset sequences.
module tb_oc8051_cy_seq;

    localparam int IDX_W = 3;
`ifdef OC8051_CY_SEQ_ZFLAG_EN
    localparam bit ZF = 1'b1;
`else
    localparam bit ZF = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [1:0] state_o;
    int         tests_run;
    int         tests_failed;

    oc8051_cy_seq_if #(.IDX_W(IDX_W)) bus ();

    oc8051_cy_seq #(.MAX_LEN(8), .IDX_W(IDX_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus.slave),
        .state_o (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] mode;
        logic [3:0] len;
        int         n;
        logic [1:0] sel0;
        logic [7:0] az;
        logic       exp_az;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " busy"}, {7'd0, bus.busy}, 8'd0);
        chk({tag, " done"}, {7'd0, bus.done}, 8'd0);
        chk({tag, " cy_sel"}, {6'd0, bus.cy_sel}, 8'd1);
        chk({tag, " we"}, {7'd0, bus.psw_cy_we}, 8'd0);
        chk({tag, " state"}, {6'd0, state_o}, 8'd0);
    endtask

    task automatic chk_byte(input string tag, input int i, input logic [1:0] sel, input logic we);
        chk({tag, " cy_sel"}, {6'd0, bus.cy_sel}, {6'd0, sel});
        chk({tag, " byte_idx"}, {5'd0, bus.byte_idx}, 8'(i));
        chk({tag, " we"}, {7'd0, bus.psw_cy_we}, {7'd0, we});
        chk({tag, " busy"}, {7'd0, bus.busy}, 8'd1);
        chk({tag, " done"}, {7'd0, bus.done}, 8'd0);
    endtask

    task automatic chk_done(input string tag, input logic exp_az);
        chk({tag, " done"}, {7'd0, bus.done}, 8'd1);
        chk({tag, " done busy"}, {7'd0, bus.busy}, 8'd1);
        chk({tag, " done we"}, {7'd0, bus.psw_cy_we}, 8'd0);
        chk({tag, " done cy_sel"}, {6'd0, bus.cy_sel}, 8'd1);
        chk({tag, " all_zero"}, {7'd0, bus.all_zero}, {7'd0, ZF ? exp_az : 1'b0});
    endtask

    // Entered at a drive point; leaves at a drive point after the closing IDLE cycle.
    task automatic run_vec(input vec_t v, input string tag);
        bus.mode  = v.mode;
        bus.len   = v.len;
        bus.start = 1'b1;
        @(negedge clk);
        chk_idle({tag, " pre"});
        to_drive();
        bus.start = 1'b0;
        for (int i = 0; i < v.n; i++) begin
            bus.alu_zero = v.az[i];
            @(negedge clk);
            chk_byte(tag, i, (i == 0) ? v.sel0 : 2'b01, 1'b1);
            to_drive();
        end
        @(negedge clk);
        chk_done(tag, v.exp_az);
        to_drive();
        @(negedge clk);
        chk_idle({tag, " post"});
        chk({tag, " post byte_idx"}, {5'd0, bus.byte_idx}, 8'd0);
        to_drive();
    endtask

    initial begin
        int run_cycles;
        int done_seen;
        vec_t v;
        tests_run    = 0;
        tests_failed = 0;

        vecs[0] = '{mode: 2'b00, len: 4'd3,  n: 3, sel0: 2'b00, az: 8'h07, exp_az: 1'b1};
        vecs[1] = '{mode: 2'b10, len: 4'd2,  n: 2, sel0: 2'b11, az: 8'h00, exp_az: 1'b0};
        vecs[2] = '{mode: 2'b01, len: 4'd1,  n: 1, sel0: 2'b01, az: 8'h01, exp_az: 1'b1};
        vecs[3] = '{mode: 2'b11, len: 4'd5,  n: 1, sel0: 2'b10, az: 8'h01, exp_az: 1'b1};
        vecs[4] = '{mode: 2'b00, len: 4'd0,  n: 1, sel0: 2'b00, az: 8'h00, exp_az: 1'b0};
        vecs[5] = '{mode: 2'b00, len: 4'd12, n: 8, sel0: 2'b00, az: 8'hFF, exp_az: 1'b1};
        vecs[6] = '{mode: 2'b00, len: 4'd3,  n: 3, sel0: 2'b00, az: 8'h05, exp_az: 1'b0};
        vecs[7] = '{mode: 2'b10, len: 4'd8,  n: 8, sel0: 2'b11, az: 8'hEF, exp_az: 1'b0};

        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.mode     = 2'b00;
        bus.len      = 4'd0;
        bus.stall    = 1'b0;
        bus.alu_zero = 1'b0;
        to_drive();
        to_drive();
        @(negedge clk);
        chk_idle("reset");
        chk("reset byte_idx", {5'd0, bus.byte_idx}, 8'd0);
        chk("reset all_zero", {7'd0, bus.all_zero}, 8'd0);
        to_drive();
        rst = 1'b0;
        to_drive();

        for (int k = 0; k < 8; k++) begin
            run_vec(vecs[k], $sformatf("vec%0d", k));
        end

        // Stall two cycles on byte 1; start and stall together in IDLE still start.
        run_cycles   = 0;
        bus.mode     = 2'b00;
        bus.len      = 4'd3;
        bus.start    = 1'b1;
        bus.stall    = 1'b1;
        bus.alu_zero = 1'b1;
        @(negedge clk);
        chk_idle("stall pre");
        to_drive();
        bus.start = 1'b0;
        bus.stall = 1'b0;
        @(negedge clk);
        chk_byte("stall b0", 0, 2'b00, 1'b1);
        if (state_o == 2'd1) run_cycles++;
        to_drive();
        bus.stall = 1'b1;
        for (int s = 0; s < 2; s++) begin
            @(negedge clk);
            chk_byte("stall hold", 1, 2'b01, 1'b0);
            if (state_o == 2'd1) run_cycles++;
            to_drive();
        end
        bus.stall = 1'b0;
        @(negedge clk);
        chk_byte("stall b1", 1, 2'b01, 1'b1);
        if (state_o == 2'd1) run_cycles++;
        to_drive();
        @(negedge clk);
        chk_byte("stall b2", 2, 2'b01, 1'b1);
        if (state_o == 2'd1) run_cycles++;
        to_drive();
        bus.stall = 1'b1;
        @(negedge clk);
        chk_done("stall", 1'b1);
        to_drive();
        bus.stall = 1'b0;
        @(negedge clk);
        chk_idle("stall post");
        chk("stall run cycles", 8'(run_cycles), 8'd5);
        to_drive();

        // Start pulsed mid-run is ignored and not queued.
        bus.mode  = 2'b00;
        bus.len   = 4'd3;
        bus.start = 1'b1;
        to_drive();
        bus.start = 1'b0;
        @(negedge clk);
        chk_byte("ign b0", 0, 2'b00, 1'b1);
        to_drive();
        bus.start = 1'b1;
        bus.mode  = 2'b11;
        bus.len   = 4'd1;
        @(negedge clk);
        chk_byte("ign b1", 1, 2'b01, 1'b1);
        to_drive();
        bus.start = 1'b0;
        @(negedge clk);
        chk_byte("ign b2", 2, 2'b01, 1'b1);
        to_drive();
        bus.start = 1'b1;
        @(negedge clk);
        chk("ign done", {7'd0, bus.done}, 8'd1);
        to_drive();
        bus.start = 1'b0;
        @(negedge clk);
        chk_idle("ign post");
        to_drive();
        @(negedge clk);
        chk_idle("ign post2");
        to_drive();

        // Reset at byte 2 of a 6-byte run: abandon with no done pulse.
        bus.mode  = 2'b01;
        bus.len   = 4'd6;
        bus.start = 1'b1;
        to_drive();
        bus.start = 1'b0;
        to_drive();
        to_drive();
        rst = 1'b1;
        @(negedge clk);
        chk_byte("rst b2", 2, 2'b01, 1'b1);
        to_drive();
        rst = 1'b0;
        @(negedge clk);
        chk_idle("rst after");
        chk("rst byte_idx", {5'd0, bus.byte_idx}, 8'd0);
        chk("rst all_zero", {7'd0, bus.all_zero}, 8'd0);
        done_seen = 0;
        for (int c = 0; c < 6; c++) begin
            to_drive();
            @(negedge clk);
            if (bus.done) done_seen++;
        end
        chk("rst no done", 8'(done_seen), 8'd0);
        to_drive();

        v = '{mode: 2'b00, len: 4'd4, n: 4, sel0: 2'b00, az: 8'h0F, exp_az: 1'b1};
        run_vec(v, "rst rerun");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
